// File: rtl/sys_reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : sys_reset_sequencer_if
// Description : Control/status bundle between the reset sequencer and the
//               system manager, IOPLL and device init-done source.
// Revision    : 1.0 - initial release
// ============================================================================
interface sys_reset_sequencer_if;
  logic       ninit_done;
  logic       pll_locked;
  logic       sw_reset_req;
  logic       pll_reset;
  logic       sys_reset_n;
  logic       dma0_reset_n;
  logic       dma1_reset_n;
  logic       seq_ready;
  logic       seq_fail;
  logic [2:0] seq_state;
  logic [7:0] retry_count;
  logic [7:0] lock_loss_count;

  // Sequencer side
  modport master (
    input  ninit_done, pll_locked, sw_reset_req,
    output pll_reset, sys_reset_n, dma0_reset_n, dma1_reset_n,
           seq_ready, seq_fail, seq_state, retry_count, lock_loss_count
  );

  // System-manager / environment side
  modport slave (
    output ninit_done, pll_locked, sw_reset_req,
    input  pll_reset, sys_reset_n, dma0_reset_n, dma1_reset_n,
           seq_ready, seq_fail, seq_state, retry_count, lock_loss_count
  );
endinterface
`default_nettype wire

// File: rtl/sys_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sys_reset_sequencer
// Description : Init-done wait, IOPLL reset/lock qualification with retry,
//               then staggered release of system and DMA RX-port resets.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 100,
  parameter int unsigned LOCK_TIMEOUT   = 10000,
  parameter int unsigned STABLE_CYCLES  = 1000,
  parameter int unsigned STAGGER_CYCLES = 16,
  parameter int unsigned MAX_RETRIES    = 4
) (
  input  wire logic             clk_clk,
  input  wire logic             reset_reset,
  sys_reset_sequencer_if.master seq
);

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_PLL_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_REL_SYS   = 3'd4,
    ST_REL_DMA0  = 3'd5,
    ST_RUN       = 3'd6,
    ST_FAIL      = 3'd7
  } state_t;

  localparam logic [15:0] C_PLL_LAST     = 16'(PLL_RST_CYCLES - 1);
  localparam logic [15:0] C_TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] C_STABLE_LAST  = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] C_STAGGER_LAST = 16'(STAGGER_CYCLES - 1);
  localparam logic [7:0]  C_MAX_RETRIES  = 8'(MAX_RETRIES);

  logic        ninit_meta_q, ninit_s_q;
  logic        lock_meta_q, lock_s_q;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  loss_q, loss_d;
  logic        pll_reset_q, pll_reset_d;
  logic        sys_rst_n_q, sys_rst_n_d;
  logic        dma0_rst_n_q, dma0_rst_n_d;
  logic        dma1_rst_n_q, dma1_rst_n_d;
  logic        ready_q, ready_d;
  logic        fail_q, fail_d;

  logic        enter;
  logic        released;
  logic        lock_lost;
  logic [7:0]  retry_inc;

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    loss_d    = loss_q;
    enter     = 1'b0;
    retry_inc = retry_q + 8'd1;
    released  = (state_q == ST_REL_SYS) || (state_q == ST_REL_DMA0) ||
                (state_q == ST_RUN);
    lock_lost = released && !lock_s_q;

    // Lock loss is counted even when a software request wins the transition
    if (lock_lost && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end

    if (seq.sw_reset_req && (state_q != ST_INIT)) begin
      state_d = ST_PLL_RST;
      retry_d = 8'd0;
      enter   = 1'b1;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          if (!ninit_s_q) begin
            state_d = ST_PLL_RST;
            enter   = 1'b1;
          end
        end
        ST_PLL_RST: begin
          if (cnt_q == C_PLL_LAST) begin
            state_d = ST_WAIT_LOCK;
            enter   = 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = ST_STABLE;
            enter   = 1'b1;
          end else if (cnt_q == C_TIMEOUT_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == C_MAX_RETRIES) ? ST_FAIL : ST_PLL_RST;
            enter   = 1'b1;
          end
        end
        ST_STABLE: begin
          if (!lock_s_q) begin
            state_d = ST_WAIT_LOCK;
            enter   = 1'b1;
          end else if (cnt_q == C_STABLE_LAST) begin
            state_d = ST_REL_SYS;
            enter   = 1'b1;
          end
        end
        ST_REL_SYS, ST_REL_DMA0: begin
          if (lock_lost) begin
            state_d = ST_PLL_RST;
            enter   = 1'b1;
          end else if (cnt_q == C_STAGGER_LAST) begin
            state_d = (state_q == ST_REL_SYS) ? ST_REL_DMA0 : ST_RUN;
            enter   = 1'b1;
          end
        end
        ST_RUN: begin
          if (lock_lost) begin
            state_d = ST_PLL_RST;
            enter   = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Saturating counter so holding states never wrap into a false match
    if (enter) begin
      cnt_d = 16'd0;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end

    pll_reset_d  = (state_d == ST_INIT) || (state_d == ST_PLL_RST) ||
                   (state_d == ST_FAIL);
    sys_rst_n_d  = (state_d == ST_REL_SYS) || (state_d == ST_REL_DMA0) ||
                   (state_d == ST_RUN);
    dma0_rst_n_d = (state_d == ST_REL_DMA0) || (state_d == ST_RUN);
    dma1_rst_n_d = (state_d == ST_RUN);
    ready_d      = (state_d == ST_RUN);
    fail_d       = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      ninit_meta_q <= 1'b1;
      ninit_s_q    <= 1'b1;
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
      state_q      <= ST_INIT;
      cnt_q        <= 16'd0;
      retry_q      <= 8'd0;
      loss_q       <= 8'd0;
      pll_reset_q  <= 1'b1;
      sys_rst_n_q  <= 1'b0;
      dma0_rst_n_q <= 1'b0;
      dma1_rst_n_q <= 1'b0;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      ninit_meta_q <= seq.ninit_done;
      ninit_s_q    <= ninit_meta_q;
      lock_meta_q  <= seq.pll_locked;
      lock_s_q     <= lock_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      pll_reset_q  <= pll_reset_d;
      sys_rst_n_q  <= sys_rst_n_d;
      dma0_rst_n_q <= dma0_rst_n_d;
      dma1_rst_n_q <= dma1_rst_n_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
    end
  end

  assign seq.pll_reset       = pll_reset_q;
  assign seq.sys_reset_n     = sys_rst_n_q;
  assign seq.dma0_reset_n    = dma0_rst_n_q;
  assign seq.dma1_reset_n    = dma1_rst_n_q;
  assign seq.seq_ready       = ready_q;
  assign seq.seq_fail        = fail_q;
  assign seq.seq_state       = state_q;
  assign seq.retry_count     = retry_q;
  assign seq.lock_loss_count = loss_q;

endmodule
`default_nettype wire

// File: doc/sys_reset_sequencer.md
Name: sys_reset_sequencer

Overview:
- Power-on and recovery reset sequencer for the system-manager subsystem.
- Waits for device init-done, pulses the ToD-sync sampling IOPLL reset, and qualifies PLL lock (timeout/retry plus a stability window).
- Then releases the system reset and the two DMA RX-port resets in a staggered order.
- Outputs drive the system manager's rst_in_in_reset and dma_subsys_port{0,1}_rx_dma_resetn_in_reset inputs and the IOPLL reset input.

Parameters:
- PLL_RST_CYCLES, 100: cycles the PLL reset is held asserted per attempt.
- LOCK_TIMEOUT, 10000: cycles to wait for lock before retrying.
- STABLE_CYCLES, 1000: consecutive locked cycles required before release.
- STAGGER_CYCLES, 16: spacing between sys, DMA0 and DMA1 releases.
- MAX_RETRIES, 4: lock-timeout attempts before entering FAIL (range 1..255).

Ports:
- clk_clk  in  1  100 MHz system clock.
- reset_reset  in  1  synchronous, active-high reset.
- ninit_done  in  1  async; 1 = device init not done.
- pll_locked  in  1  async IOPLL lock.
- sw_reset_req  in  1  sync single-cycle re-sequence request.
- pll_reset  out  1  IOPLL reset, active high.
- sys_reset_n  out  1  system reset, active low.
- dma0_reset_n  out  1  DMA port0 RX reset, active low.
- dma1_reset_n  out  1  DMA port1 RX reset, active low.
- seq_ready  out  1  sequence complete (RUN state).
- seq_fail  out  1  retries exhausted.
- seq_state  out  3  current state encoding.
- retry_count  out  8  lock timeouts since last sequence start.
- lock_loss_count  out  8  saturating count of lock losses after qualification.

Behaviour:
- Clocking and reset: one clock domain. Synchronous, active-high reset on clk_clk; reset_reset also clears mid-operation state.
- Reset values: pll_reset=1, sys_reset_n=0, dma0_reset_n=0, dma1_reset_n=0, seq_ready=0, seq_fail=0, seq_state=0, retry_count=0, lock_loss_count=0.
- Input synchronisers: ninit_done and pll_locked each pass through a 2-flop synchroniser (reset values 1 and 0 respectively), giving the _s signals. Latency is 2 cycles.
- Output registers: all outputs are registered and change on the same edge as seq_state. Each state has one cycle counter, cleared on every state entry.
- State encoding and output decode:
  - INIT=0, PLL_RST=1, WAIT_LOCK=2, STABLE=3, REL_SYS=4, REL_DMA0=5, RUN=6, FAIL=7.
  - pll_reset=1 in INIT, PLL_RST and FAIL.
  - sys_reset_n=1 in REL_SYS, REL_DMA0 and RUN.
  - dma0_reset_n=1 in REL_DMA0 and RUN.
  - dma1_reset_n=1 in RUN only.
  - seq_ready=1 in RUN; seq_fail=1 in FAIL.
- State transitions:
  - INIT: ninit_done_s==0 -> PLL_RST.
  - PLL_RST: after PLL_RST_CYCLES cycles in state -> WAIT_LOCK.
  - WAIT_LOCK: if pll_locked_s==1 -> STABLE. Otherwise, once LOCK_TIMEOUT cycles have elapsed: retry_count++; if the new value equals MAX_RETRIES -> FAIL, else -> PLL_RST.
  - STABLE: pll_locked_s==0 -> WAIT_LOCK (timeout restarts, no retry increment). After STABLE_CYCLES consecutive locked cycles -> REL_SYS.
  - REL_SYS: after STAGGER_CYCLES -> REL_DMA0.
  - REL_DMA0: after STAGGER_CYCLES -> RUN.
  - RUN: holds until an event.
  - FAIL: holds until sw_reset_req.
- Lock loss in REL_SYS, REL_DMA0 or RUN:
  - pll_locked_s==0 -> lock_loss_count++ (saturate at 255) and go to PLL_RST.
  - All resets reassert on that same edge.
- sw_reset_req (any state except INIT):
  - Go to PLL_RST and clear retry_count; has priority over all other transitions.
  - If it coincides with a lock loss, the lock loss is still counted.
- Ignored events:
  - sw_reset_req in INIT.
  - ninit_done_s rising after INIT has been left.
- Counter rule: the elapsed check is counter==N-1, i.e. exactly N cycles in state. Counters are 16 bits wide; parameters are limited to 1..65535.

Test Plan:
- Bench overrides: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, STAGGER_CYCLES=3, MAX_RETRIES=2.
- Nominal bring-up: reset, then ninit_done=0 at cycle 10, pll_locked=1 from cycle 30.
  - pll_reset falls exactly 4 cycles after PLL_RST entry.
  - sys_reset_n rises 8 cycles after STABLE entry.
  - dma0_reset_n rises 3 cycles later; dma1_reset_n and seq_ready rise 3 cycles after that.
  - seq_state ends at 6.
- Lock never asserts: two timeouts of 20 cycles occur.
  - retry_count goes 1 then 2; seq_fail=1; seq_state=7; pll_reset=1.
  - Then sw_reset_req -> retry_count=0 and seq_state=1.
- Lock glitch in STABLE: pll_locked low for 1 cycle at STABLE count 5.
  - Returns to WAIT_LOCK; sys_reset_n stays 0; retry_count unchanged.
  - Release occurs 8 cycles after re-entry to STABLE.
- Lock loss in RUN: drop pll_locked.
  - Exactly 2 cycles later: all three resets assert, pll_reset=1, lock_loss_count=1, seq_state=1.
  - Full re-sequence completes to RUN.
- Simultaneous sw_reset_req and lock loss in RUN: lock_loss_count increments, retry_count=0, next state PLL_RST.
- Mid-sequence reset_reset (in REL_DMA0) and lock-loss saturation:
  - After reset_reset, all outputs return to their reset values next cycle.
  - 300 lock losses leave lock_loss_count=255.
